// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants: beat select encoding, pair field offsets, splitter FSM states
package fft_pkg;

    localparam logic SEL_REAL = 1'b0;
    localparam logic SEL_IMAG = 1'b1;

    // Component positions (in data_width units) inside a packed complex pair
    localparam int ZR1_IDX = 0;
    localparam int ZI1_IDX = 1;
    localparam int ZR2_IDX = 2;
    localparam int ZI2_IDX = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REAL = 2'd1,
        ST_IMAG = 2'd2
    } split_state_e;

endpackage

// File: rtl/cplx_pair_unpack.sv
// rtl/cplx_pair_unpack.sv - selects the {z2,z1} real or imaginary slice of a packed complex pair
module cplx_pair_unpack
    import fft_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic [4*data_width-1:0] pair_data,
    input  logic                    sel,
    output logic [2*data_width-1:0] beat_data
);

    always_comb begin
        if (sel == SEL_IMAG) begin
            beat_data = {pair_data[ZI2_IDX*data_width +: data_width],
                         pair_data[ZI1_IDX*data_width +: data_width]};
        end else begin
            beat_data = {pair_data[ZR2_IDX*data_width +: data_width],
                         pair_data[ZR1_IDX*data_width +: data_width]};
        end
    end

endmodule

// File: rtl/reg_in_split.sv
// rtl/reg_in_split.sv - splits a packed complex pair into two beats (reals, imags); REG_IN_IMAG_FIRST_EN swaps beat order
module reg_in_split
    import fft_pkg::*;
#(
    parameter int NO_comp_word = 2,
    parameter int data_width   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [2*NO_comp_word*data_width-1:0] in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [NO_comp_word*data_width-1:0]   out_data,
    output logic                                 out_sel,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int PW = 2 * NO_comp_word * data_width;
    localparam int BW = NO_comp_word * data_width;

    // ST_REAL/ST_IMAG mean first/second beat; the macro only changes which component goes first
`ifdef REG_IN_IMAG_FIRST_EN
    localparam logic FIRST_SEL  = SEL_IMAG;
`else
    localparam logic FIRST_SEL  = SEL_REAL;
`endif
    localparam logic SECOND_SEL = ~FIRST_SEL;

    split_state_e  state_q, state_d;
    logic [PW-1:0] cur_q, cur_d;
    logic [PW-1:0] nxt_q, nxt_d;
    logic          nxt_full_q, nxt_full_d;
    logic [BW-1:0] out_data_q, out_data_d;
    logic          out_sel_q, out_sel_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;
    logic          accept;
    logic          beat_sel;
    logic [BW-1:0] beat_data;

    assign in_ready  = enable & ~nxt_full_q;
    assign accept    = in_valid & in_ready;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            nxt_q       <= '0;
            nxt_full_q  <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            nxt_full_q  <= nxt_full_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        nxt_full_d = nxt_full_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_REAL;
                        cur_d   = in_data;
                    end
                end
                ST_REAL: begin
                    if (out_ready) state_d = ST_IMAG;
                    if (accept) begin
                        nxt_d      = in_data;
                        nxt_full_d = 1'b1;
                    end
                end
                ST_IMAG: begin
                    if (out_ready) begin
                        // accept cannot coincide with nxt_full, since in_ready is low then
                        if (nxt_full_q) begin
                            state_d    = ST_REAL;
                            cur_d      = nxt_q;
                            nxt_full_d = 1'b0;
                        end else if (accept) begin
                            state_d = ST_REAL;
                            cur_d   = in_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (accept) begin
                        nxt_d      = in_data;
                        nxt_full_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign beat_sel = (state_d == ST_IMAG) ? SECOND_SEL : FIRST_SEL;

    cplx_pair_unpack #(
        .data_width (data_width)
    ) u_unpack (
        .pair_data (cur_d),
        .sel       (beat_sel),
        .beat_data (beat_data)
    );

    // Outputs are precomputed from next state so they come straight from flops
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (enable) begin
            case (state_d)
                ST_REAL: begin
                    out_valid_d = 1'b1;
                    out_sel_d   = FIRST_SEL;
                    out_last_d  = 1'b0;
                    out_data_d  = beat_data;
                end
                ST_IMAG: begin
                    out_valid_d = 1'b1;
                    out_sel_d   = SECOND_SEL;
                    out_last_d  = 1'b1;
                    out_data_d  = beat_data;
                end
                default: out_valid_d = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_in_split.sv
// tb/tb_reg_in_split.sv - directed self-checking bench for reg_in_split
module tb_reg_in_split;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_sel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int tests;
    int fails;

`ifdef REG_IN_IMAG_FIRST_EN
    localparam logic [15:0] A1 = 16'h4422, A2 = 16'h3311;
    localparam logic [15:0] B1 = 16'h8866, B2 = 16'h7755;
    localparam logic        S1 = 1'b1,     S2 = 1'b0;
`else
    localparam logic [15:0] A1 = 16'h3311, A2 = 16'h4422;
    localparam logic [15:0] B1 = 16'h7755, B2 = 16'h8866;
    localparam logic        S1 = 1'b0,     S2 = 1'b1;
`endif
    localparam logic [31:0] PA = 32'h44332211;
    localparam logic [31:0] PB = 32'h88776655;

    reg_in_split #(
        .NO_comp_word (2),
        .data_width   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [15:0] d, input logic s, input logic l);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".data"}, {16'd0, out_data}, {16'd0, d});
        check({tag, ".sel"}, {31'd0, out_sel}, {31'd0, s});
        check({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0; enable = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.data", {16'd0, out_data}, 32'd0);
        check("rst.sel", {31'd0, out_sel}, 32'd0);
        check("rst.last", {31'd0, out_last}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;

        // single pair
        in_data = PA; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_beat("single.b1", A1, S1, 1'b0);
        step();
        check_beat("single.b2", A2, S2, 1'b1);
        step();
        check("single.idle", {31'd0, out_valid}, 32'd0);

        // back-to-back, no bubbles
        in_data = PA; in_valid = 1'b1;
        step();
        check_beat("b2b.a1", A1, S1, 1'b0);
        check("b2b.rdy_a1", {31'd0, in_ready}, 32'd1);
        in_data = PB;
        step();
        in_valid = 1'b0;
        check_beat("b2b.a2", A2, S2, 1'b1);
        check("b2b.rdy_full", {31'd0, in_ready}, 32'd0);
        step();
        check_beat("b2b.b1", B1, S1, 1'b0);
        check("b2b.rdy_free", {31'd0, in_ready}, 32'd1);
        step();
        check_beat("b2b.b2", B2, S2, 1'b1);
        step();
        check("b2b.idle", {31'd0, out_valid}, 32'd0);

        // backpressure during first beat
        out_ready = 1'b0; in_data = PA; in_valid = 1'b1;
        step();
        in_data = PB;
        step();
        in_valid = 1'b0;
        check("bp.rdy_full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_beat("bp.stall", A1, S1, 1'b0);
            check("bp.rdy_stall", {31'd0, in_ready}, 32'd0);
            step();
        end
        check_beat("bp.stall_end", A1, S1, 1'b0);
        out_ready = 1'b1;
        step();
        check_beat("bp.a2", A2, S2, 1'b1);
        step();
        check_beat("bp.b1", B1, S1, 1'b0);
        step();
        check_beat("bp.b2", B2, S2, 1'b1);
        step();
        check("bp.idle", {31'd0, out_valid}, 32'd0);

        // reset in the middle of a pair with a pending pair
        in_data = PA; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = PB;
        step();
        in_valid = 1'b0;
        check_beat("mrst.a2", A2, S2, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mrst.valid", {31'd0, out_valid}, 32'd0);
        check("mrst.data", {16'd0, out_data}, 32'd0);
        check("mrst.sel", {31'd0, out_sel}, 32'd0);
        check("mrst.last", {31'd0, out_last}, 32'd0);
        check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("mrst.lost", {31'd0, out_valid}, 32'd0);

        // enable low mid-stream
        in_data = PA; in_valid = 1'b1;
        step();
        enable = 1'b0; in_data = PB;
        for (int i = 0; i < 3; i++) begin
            step();
            check_beat("en.hold", A1, S1, 1'b0);
            check("en.rdy", {31'd0, in_ready}, 32'd0);
        end
        enable = 1'b1; in_valid = 1'b0;
        step();
        check_beat("en.a2", A2, S2, 1'b1);
        step();
        check("en.idle", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_in_split.md
Name: reg_in_split

Overview:
- Inverse of the FFT output collector: takes one packed complex pair {zi2, zr2, zi1, zr1} and emits it as two beats to the butterfly datapath, reals first, then imaginaries.
- Sits between the sample source/memory and the FFT butterfly input.
- Valid/ready on both sides; one-entry pending buffer so a new pair can be accepted while the current one drains.

Parameters:
- NO_comp_word, 2, complex words per pair; fixed at 2 for this block.
- data_width, 8, bits per real or imaginary component.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- enable  in  1  clock enable; when 0, all state holds.
- in_data  in  2*NO_comp_word*data_width  packed pair: zr1[dw-1:0], zi1[2dw-1:dw], zr2[3dw-1:2dw], zi2[4dw-1:3dw].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data.
- out_data  out  NO_comp_word*data_width  beat payload: {z2 part, z1 part}, z1 in low dw bits.
- out_sel  out  1  0 = real beat, 1 = imag beat (same encoding as the collector's sel).
- out_last  out  1  high on the second beat of a pair.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts beat.

Behaviour:
- Reset: synchronous on rst==0 at a clk edge; overrides enable. out_data=0, out_sel=0, out_last=0, out_valid=0, pending buffer empty, FSM=IDLE. A pair in progress is discarded.
- Storage: cur register (pair being emitted), nxt register (one pending pair, with nxt_full flag).
- in_ready = enable & !nxt_full, combinational from registers only; no in_valid→in_ready path.
- Accept when in_valid & in_ready at an edge with enable=1.
- FSM states:
  - IDLE: out_valid=0.
  - REAL: out_valid=1, out_sel=0, out_last=0, out_data={zr2,zr1}.
  - IMAG: out_valid=1, out_sel=1, out_last=1, out_data={zi2,zi1}.
- Transitions:
  - IDLE→REAL on accept; data loads into cur directly, bypassing nxt.
  - REAL→IMAG when out_ready.
  - IMAG→REAL when out_ready and (nxt_full or an accept this cycle); cur loads from nxt if nxt_full, else from in_data.
  - IMAG→IDLE when out_ready and no pending pair.
- Accept in REAL or IMAG without a beat completion: data goes to nxt and nxt_full sets.
- Simultaneous IMAG handoff and accept with nxt_full=1 cannot happen, since in_ready=0.
- nxt_full clears when its contents move to cur.
- Latency: accept at edge N → REAL beat valid after edge N (visible in cycle N+1). No bubble between pairs when out_ready stays high: one pair per 2 cycles, sustained.
- out_valid, out_data, out_sel and out_last are all registered and stable while out_ready=0 (no payload change while stalled).
- enable=0: no state change; in_ready=0; outputs hold their value.
- No arithmetic; pure field selection, widths exact, no sign handling.

Optional Feature:
- Macro REG_IN_IMAG_FIRST_EN.
- Defined: beat order swapped. First beat out_sel=1, data {zi2,zi1}; second beat out_sel=0, data {zr2,zr1}, out_last=1.
- Undefined: reals first, as above.
- Reset value of out_sel remains 0 in both cases.

Decomposition:
- Shared package fft_pkg:
  - SEL_REAL=1'b0, SEL_IMAG=1'b1.
  - Field offset constants ZR1_IDX=0, ZI1_IDX=1, ZR2_IDX=2, ZI2_IDX=3, also used by the collector.
  - FSM state encoding IDLE/REAL/IMAG.
- One natural sub-module: cplx_pair_unpack. Combinational; takes the packed pair plus a beat select and returns the {z2,z1} real or imag slice. It is reused by any future unpacker.

Test Plan:
- Single pair: reset, in_data=32'h44332211, out_ready=1 → REAL beat out_data=16'h3311, sel=0, last=0; next cycle IMAG beat 16'h4422, sel=1, last=1; then out_valid=0.
- Back-to-back: send 32'h44332211 then 32'h88776655 with in_valid held and out_ready=1 → beats 3311, 4422, 7755, 8866 on consecutive cycles, no bubbles; in_ready drops for exactly one cycle while nxt is full.
- Backpressure: out_ready=0 for 5 cycles during the REAL beat → out_data stays 16'h3311, out_valid=1; one more pair is accepted, then in_ready=0 until it drains.
- Mid-pair reset: rst=0 during the IMAG beat → next cycle out_valid=0, out_data=0, in_ready=1, pending pair lost.
- enable=0 for 3 cycles mid-stream → no state change, no accept, outputs frozen; resumes on the same beat.
- With REG_IN_IMAG_FIRST_EN defined, pair 32'h44332211 → beats 16'h4422 sel=1, then 16'h3311 sel=0 last=1.
